// File: rtl/phase_select_ctrl_if.sv
// Bundle between the CDR phase detector/mux and the phase-pointer controller.
// PSC_MANUAL_EN adds the manual phase override signals.
interface phase_select_ctrl_if #(
    parameter int unsigned PTR_W = 4
);
    logic             en;
    logic             shift_right;
    logic             shift_left;
    logic [PTR_W-1:0] phase_sel;
    logic             step_up;
    logic             step_dn;
    logic             locked;
    logic             trk_mode;
`ifdef PSC_MANUAL_EN
    logic             man_en;
    logic [PTR_W-1:0] man_phase;

    modport master (
        output en, shift_right, shift_left, man_en, man_phase,
        input  phase_sel, step_up, step_dn, locked, trk_mode
    );
    modport slave (
        input  en, shift_right, shift_left, man_en, man_phase,
        output phase_sel, step_up, step_dn, locked, trk_mode
    );
`else
    modport master (
        output en, shift_right, shift_left,
        input  phase_sel, step_up, step_dn, locked, trk_mode
    );
    modport slave (
        input  en, shift_right, shift_left,
        output phase_sel, step_up, step_dn, locked, trk_mode
    );
`endif
endinterface

// File: rtl/phase_select_ctrl.sv
// Loop filter and phase-pointer controller for the 16-phase oversampling CDR.
// Define PSC_MANUAL_EN to enable the manual phase override (man_en/man_phase).
module phase_select_ctrl #(
    parameter int unsigned NPHASE     = 16,
    parameter int unsigned PTR_W      = 4,
    parameter int unsigned ACQ_THRESH = 2,
    parameter int unsigned TRK_THRESH = 8,
    parameter int unsigned ACC_W      = 5,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned LOCK_WIN   = 64,
    parameter int unsigned UNLOCK_RUN = 3
) (
    input  logic                clk,
    input  logic                rst,
    phase_select_ctrl_if.slave  bus
);
    localparam int unsigned SW  = ACC_W + 1;
    localparam int unsigned LW  = $clog2(LOCK_WIN + 1);
    localparam int unsigned RW  = $clog2(UNLOCK_RUN + 1);
    localparam int unsigned SCW = $clog2(SETTLE_CYC + 1);

    typedef enum logic [1:0] {S_ACQ = 2'd0, S_TRACK = 2'd1, S_SETTLE = 2'd2} state_e;

    state_e                   state_q, state_d, ret_q, ret_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [PTR_W-1:0]         phase_q, phase_d;
    logic [LW-1:0]            lock_cnt_q, lock_cnt_d;
    logic [RW-1:0]            run_cnt_q, run_cnt_d;
    logic [SCW-1:0]           settle_cnt_q, settle_cnt_d;
    logic                     last_up_q, last_up_d;
    logic                     step_up_q, step_up_d, step_dn_q, step_dn_d;
    logic                     locked_q, locked_d, trk_q, trk_d;

    logic signed [1:0]        vote;
    logic signed [SW-1:0]     sum, thr;
    logic [RW-1:0]            run_next;
    logic                     up;

    // Next-state: vote integration, stepping, settle timing, lock/unlock tracking.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        acc_d        = acc_q;
        phase_d      = phase_q;
        lock_cnt_d   = lock_cnt_q;
        run_cnt_d    = run_cnt_q;
        settle_cnt_d = settle_cnt_q;
        last_up_d    = last_up_q;
        step_up_d    = 1'b0;
        step_dn_d    = 1'b0;
        locked_d     = locked_q;
        trk_d        = trk_q;
        run_next     = '0;
        up           = 1'b0;

        vote = 2'sb00;
        if (bus.shift_right && !bus.shift_left)      vote = 2'sb01;
        else if (bus.shift_left && !bus.shift_right) vote = 2'sb11;
        sum = SW'(acc_q) + SW'(vote);
        thr = (state_q == S_TRACK) ? SW'(TRK_THRESH) : SW'(ACQ_THRESH);

        if (state_q == S_SETTLE) begin
            if (settle_cnt_q == SCW'(SETTLE_CYC - 1)) begin
                state_d      = ret_q;
                settle_cnt_d = '0;
            end else begin
                settle_cnt_d = settle_cnt_q + SCW'(1);
            end
        end else if (bus.en) begin
            if (sum == thr || sum == -thr) begin
                up           = (sum == thr);
                step_up_d    = up;
                step_dn_d    = !up;
                if (up) phase_d = (phase_q == PTR_W'(NPHASE - 1)) ? '0 : phase_q + PTR_W'(1);
                else    phase_d = (phase_q == '0) ? PTR_W'(NPHASE - 1) : phase_q - PTR_W'(1);
                acc_d        = '0;
                lock_cnt_d   = '0;
                settle_cnt_d = '0;
                state_d      = S_SETTLE;
                ret_d        = state_q;
                if (state_q == S_TRACK) begin
                    run_next  = (run_cnt_q != '0 && last_up_q == up) ? run_cnt_q + RW'(1) : RW'(1);
                    run_cnt_d = run_next;
                    last_up_d = up;
                    // A run of same-direction steps means the loop lost the eye: fall back to ACQ.
                    if (run_next == RW'(UNLOCK_RUN)) begin
                        locked_d  = 1'b0;
                        trk_d     = 1'b0;
                        ret_d     = S_ACQ;
                        run_cnt_d = '0;
                    end
                end
            end else begin
                acc_d = ACC_W'(sum);
                if (lock_cnt_q != LW'(LOCK_WIN)) lock_cnt_d = lock_cnt_q + LW'(1);
                if (state_q == S_ACQ && lock_cnt_q == LW'(LOCK_WIN - 1)) begin
                    state_d   = S_TRACK;
                    locked_d  = 1'b1;
                    trk_d     = 1'b1;
                    run_cnt_d = '0;
                end
            end
        end

`ifdef PSC_MANUAL_EN
        if (bus.man_en) begin
            phase_d      = bus.man_phase;
            acc_d        = '0;
            lock_cnt_d   = '0;
            run_cnt_d    = '0;
            settle_cnt_d = '0;
            locked_d     = 1'b0;
            trk_d        = 1'b0;
            step_up_d    = 1'b0;
            step_dn_d    = 1'b0;
            state_d      = S_ACQ;
            ret_d        = S_ACQ;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_ACQ;
            ret_q        <= S_ACQ;
            acc_q        <= '0;
            phase_q      <= '0;
            lock_cnt_q   <= '0;
            run_cnt_q    <= '0;
            settle_cnt_q <= '0;
            last_up_q    <= 1'b0;
            step_up_q    <= 1'b0;
            step_dn_q    <= 1'b0;
            locked_q     <= 1'b0;
            trk_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            acc_q        <= acc_d;
            phase_q      <= phase_d;
            lock_cnt_q   <= lock_cnt_d;
            run_cnt_q    <= run_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            last_up_q    <= last_up_d;
            step_up_q    <= step_up_d;
            step_dn_q    <= step_dn_d;
            locked_q     <= locked_d;
            trk_q        <= trk_d;
        end
    end

    assign bus.phase_sel = phase_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_dn   = step_dn_q;
    assign bus.locked    = locked_q;
    assign bus.trk_mode  = trk_q;
endmodule
